cpu_mem_bridge: RTL and testbench

//  Responder for the core's SRAM-style inst/data ports. Returns instr/rdata and

---
 rtl/cpu_mem_bridge_if.sv | 34 +++
 rtl/cpu_mem_bridge.sv | 99 +++++++++
 tb/tb_cpu_mem_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_if.sv
// CPU-side SRAM-style inst/data ports and the single-outstanding memory bus.
// On sram_if the core is master; on mem_bus_if the bridge is master.
interface sram_if #(parameter int ADDR_W = 32);
  logic              inst_en;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              i_stall;
  logic              data_en;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wen;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              d_stall;
  logic              longest_stall;

  modport master (output inst_en, inst_addr, data_en, data_addr, data_wen, data_wdata, longest_stall,
                  input  inst_rdata, i_stall, data_rdata, d_stall);
  modport slave  (input  inst_en, inst_addr, data_en, data_addr, data_wen, data_wdata, longest_stall,
                  output inst_rdata, i_stall, data_rdata, d_stall);
endinterface

interface mem_bus_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              wr;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (output req, wr, wstrb, addr, wdata, input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/cpu_mem_bridge.sv
// Arbitrates the core's inst/data ports onto one single-outstanding memory bus
// and holds each finished result until the whole pipeline advances.
module cpu_mem_bridge #(
  parameter int ADDR_W    = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  sram_if.slave    cpu,
  mem_bus_if.master mem
);

  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

  state_t            state;
  logic              instDone, dataDone;
  logic [31:0]       instRdata, dataRdata;
  logic              memReq, memWr;
  logic [3:0]        memStrb;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;

  logic instPend, dataPend, pickData;

  assign instPend = cpu.inst_en & ~instDone;
  assign dataPend = cpu.data_en & ~dataDone;
  assign pickData = dataPend & (DATA_PRIO | ~instPend);

  assign cpu.i_stall    = instPend;
  assign cpu.d_stall    = dataPend;
  assign cpu.inst_rdata = instRdata;
  assign cpu.data_rdata = dataRdata;

  assign mem.req   = memReq;
  assign mem.wr    = memWr;
  assign mem.wstrb = memStrb;
  assign mem.addr  = memAddr;
  assign mem.wdata = memWdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      instDone  <= 1'b0;
      dataDone  <= 1'b0;
      instRdata <= '0;
      dataRdata <= '0;
      memReq    <= 1'b0;
      memWr     <= 1'b0;
      memStrb   <= '0;
      memAddr   <= '0;
      memWdata  <= '0;
    end else begin
      // Done flags drop only when the whole core advances; a set below overrides.
      if (!cpu.longest_stall) begin
        instDone <= 1'b0;
        dataDone <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pickData) begin
            state    <= D_ADDR;
            memReq   <= 1'b1;
            memWr    <= |cpu.data_wen;
            memStrb  <= cpu.data_wen;
            memAddr  <= cpu.data_addr;
            memWdata <= cpu.data_wdata;
          end else if (instPend) begin
            state    <= I_ADDR;
            memReq   <= 1'b1;
            memWr    <= 1'b0;
            memStrb  <= '0;
            memAddr  <= cpu.inst_addr;
            memWdata <= '0;
          end
        end
        I_ADDR: if (mem.addr_ok) begin
          memReq <= 1'b0;
          state  <= I_DATA;
        end
        D_ADDR: if (mem.addr_ok) begin
          memReq <= 1'b0;
          state  <= D_DATA;
        end
        I_DATA: if (mem.data_ok) begin
          instDone  <= 1'b1;
          instRdata <= mem.rdata;
          state     <= IDLE;
        end
        D_DATA: if (mem.data_ok) begin
          dataDone <= 1'b1;
          if (!memWr) dataRdata <= mem.rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed latency/reset cases, then random core + memory traffic checked
// against a transaction-level model of the bridge.
module tb_cpu_mem_bridge;
  localparam int AW   = 32;
  localparam bit PRIO = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic divHold = 1'b0;
  always #5 clk = ~clk;

  sram_if    #(.ADDR_W(AW)) cpu();
  mem_bus_if #(.ADDR_W(AW)) mem();

  assign cpu.longest_stall = cpu.i_stall | cpu.d_stall | divHold;

  cpu_mem_bridge #(.ADDR_W(AW), .DATA_PRIO(PRIO)) dut (
    .clk(clk), .rst(rst), .cpu(cpu.slave), .mem(mem.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] memArr [logic [31:0]];

  function automatic logic [31:0] rdMem(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
  endfunction

  task automatic wrMem(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] v;
    v = rdMem(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    memArr[a] = v;
  endtask

  // model state
  logic        iSrv, dSrv, iIss, dIss, capData, capWr, pI, pD, expI, expD, adv;
  logic [31:0] capAddr, capWdata, expInst, expData, old;
  logic [3:0]  capStrb;
  int          memPhase, waitCnt, divCnt, bundles;

  task automatic newBundle();
    iSrv = 0; dSrv = 0; iIss = 0; dIss = 0;
    cpu.inst_en    = ($urandom_range(0, 3) != 0);
    cpu.inst_addr  = 32'hbfc0_0000 | ($urandom & 32'hfc);
    cpu.data_en    = $urandom_range(0, 1);
    cpu.data_addr  = 32'h8000_0000 | ($urandom & 32'h3c);
    cpu.data_wen   = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    cpu.data_wdata = $urandom;
    divCnt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
    bundles++;
  endtask

  initial begin
    cpu.inst_en = 0; cpu.inst_addr = 0; cpu.data_en = 0; cpu.data_addr = 0;
    cpu.data_wen = 0; cpu.data_wdata = 0;
    mem.addr_ok = 0; mem.data_ok = 0; mem.rdata = 0;
    bundles = 0; memPhase = 0; waitCnt = 0; divCnt = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", mem.req, 0);     chk("rst_wr", mem.wr, 0);
    chk("rst_wstrb", mem.wstrb, 0); chk("rst_addr", mem.addr, 0);
    chk("rst_wdata", mem.wdata, 0); chk("rst_irdata", cpu.inst_rdata, 0);
    chk("rst_drdata", cpu.data_rdata, 0);
    chk("rst_istall", cpu.i_stall, 0); chk("rst_dstall", cpu.d_stall, 0);

    // minimum-latency fetch
    rst = 0; cpu.inst_en = 1; cpu.inst_addr = 32'hbfc0_0000; #1;
    chk("t1_c0_istall", cpu.i_stall, 1); chk("t1_c0_req", mem.req, 0);
    @(negedge clk);
    chk("t1_c1_req", mem.req, 1); chk("t1_c1_addr", mem.addr, 32'hbfc0_0000);
    chk("t1_c1_wr", mem.wr, 0); chk("t1_c1_istall", cpu.i_stall, 1);
    mem.addr_ok = 1;
    @(negedge clk);
    mem.addr_ok = 0;
    chk("t1_c2_req", mem.req, 0); chk("t1_c2_istall", cpu.i_stall, 1);
    mem.data_ok = 1; mem.rdata = 32'h2408_0001;
    @(negedge clk);
    mem.data_ok = 0;
    chk("t1_c3_istall", cpu.i_stall, 0); chk("t1_c3_rdata", cpu.inst_rdata, 32'h2408_0001);
    chk("t1_c3_req", mem.req, 0);
    cpu.inst_en = 0;

    // spurious data_ok in D_ADDR, then reset in D_DATA
    @(negedge clk);
    cpu.data_en = 1; cpu.data_addr = 32'h8000_2000; cpu.data_wen = 0;
    @(negedge clk);
    chk("t5_req", mem.req, 1); chk("t5_addr", mem.addr, 32'h8000_2000);
    mem.data_ok = 1; mem.rdata = 32'hbad0_bad0;
    @(negedge clk);
    mem.data_ok = 0;
    chk("t5_spur_dstall", cpu.d_stall, 1); chk("t5_spur_req", mem.req, 1);
    chk("t5_spur_rdata", cpu.data_rdata, 0);
    mem.addr_ok = 1;
    @(negedge clk);
    mem.addr_ok = 0;
    chk("t5_ddata_req", mem.req, 0);
    rst = 1;
    @(negedge clk);
    #1;
    chk("t5_rst_req", mem.req, 0); chk("t5_rst_dstall", cpu.d_stall, 1);
    chk("t5_rst_drdata", cpu.data_rdata, 0); chk("t5_rst_irdata", cpu.inst_rdata, 0);
    chk("t5_rst_addr", mem.addr, 0);
    rst = 0; cpu.data_en = 0;
    expInst = 0; expData = 0;

    // random traffic
    @(posedge clk); #1;
    newBundle();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      mem.addr_ok = 0; mem.data_ok = 0; mem.rdata = $urandom;
      expI = cpu.inst_en && !iSrv;
      expD = cpu.data_en && !dSrv;
      chk("i_stall", cpu.i_stall, expI);
      chk("d_stall", cpu.d_stall, expD);
      chk("inst_rdata", cpu.inst_rdata, expInst);
      chk("data_rdata", cpu.data_rdata, expData);

      if (memPhase == 0 && mem.req) begin
        pI = cpu.inst_en && !iSrv && !iIss;
        pD = cpu.data_en && !dSrv && !dIss;
        if (!pI && !pD) begin
          chk("req_unexpected", mem.req, 0);
          capData = 0;
        end else begin
          capData = pD && (PRIO || !pI);
          chk("req_wr", mem.wr, capData ? 32'(|cpu.data_wen) : 0);
          chk("req_addr", mem.addr, capData ? cpu.data_addr : cpu.inst_addr);
          if (capData) begin
            chk("req_wstrb", mem.wstrb, cpu.data_wen);
            if (|cpu.data_wen) chk("req_wdata", mem.wdata, cpu.data_wdata);
          end
        end
        if (capData) dIss = 1; else iIss = 1;
        capAddr = mem.addr; capWr = mem.wr; capStrb = mem.wstrb; capWdata = mem.wdata;
        memPhase = 1; waitCnt = $urandom_range(0, 3);
      end else if (memPhase == 0 && $urandom_range(0, 7) == 0) begin
        mem.data_ok = 1;
      end

      if (memPhase == 1) begin
        chk("hold_req", mem.req, 1);
        chk("hold_addr", mem.addr, capAddr);
        chk("hold_wdata", mem.wdata, capWdata);
        if ($urandom_range(0, 3) == 0) mem.data_ok = 1;
        if (waitCnt == 0) begin
          mem.addr_ok = 1; memPhase = 2; waitCnt = $urandom_range(0, 3);
        end else waitCnt--;
      end else if (memPhase == 2) begin
        chk("data_phase_req", mem.req, 0);
        if (waitCnt == 0) begin
          mem.data_ok = 1;
          old = rdMem(capAddr);
          mem.rdata = old;
          if (capData) begin
            if (capWr) wrMem(capAddr, capStrb, capWdata); else expData = old;
            dSrv = 1;
          end else begin
            expInst = old; iSrv = 1;
          end
          memPhase = 0;
        end else begin
          waitCnt--;
          if ($urandom_range(0, 3) == 0) mem.addr_ok = 1;
        end
      end

      divHold = (divCnt != 0);
      adv = !(expI || expD || divHold);
      if (divCnt != 0) divCnt--;
      @(posedge clk); #1;
      if (adv) newBundle();
    end
    chk("progress", 32'(bundles > 200), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
